// File: rtl/raytracing_scheduler.sv
// Raytracing strip scheduler: walks a screen-centred frame strip by strip,
// dispatches each strip to N_WORKERS raytracing workers, waits for all of
// them to finish, then drains their results as a raster-ordered pixel stream.
// Latency: DISPATCH 1 cycle, WAIT_DONE as long as the slowest worker,
// RELEASE 1 cycle, DRAIN S cycles (S = N_WORKERS*JOBS_SUBDIVISION) with
// px_ready high, ADVANCE 1 cycle.
// Backpressure: px_valid/px_ready handshake. Outputs hold while stalled, and
// the next strip is not dispatched until the current one has fully drained.
//
// Optional feature: define SCHEDULER_TIMEOUT_EN to add a WAIT_DONE watchdog
// that raises the sticky sched_error flag and abandons the frame.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   frame_start / frame_done   frame request pulse / frame complete pulse
//   w_activate, w_pixel_start_x, w_pixel_y   worker dispatch
//   w_busy, w_buffer           worker status and result buffers
//   px_valid/px_ready, px_x, px_y, px_color  pixel output stream
//   sched_error                sticky watchdog flag (0 unless timeout enabled)

package Types;
  typedef logic [23:0] Color;
endpackage

module raytracing_scheduler #(
  parameter int N_WORKERS        = 4,
  parameter int JOBS_SUBDIVISION = 8,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic                                                frame_start,
  output logic                                                frame_done,
  output logic [N_WORKERS-1:0]                                w_activate,
  output logic signed [11:0]                                  w_pixel_start_x,
  output logic signed [11:0]                                  w_pixel_y,
  input  logic [N_WORKERS-1:0]                                w_busy,
  input  Types::Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0]   w_buffer,
  output logic                                                px_valid,
  input  logic                                                px_ready,
  output logic signed [11:0]                                  px_x,
  output logic signed [11:0]                                  px_y,
  output Types::Color                                         px_color,
  output logic                                                sched_error
);

  localparam int S  = N_WORKERS * JOBS_SUBDIVISION;
  localparam int PW = (S > 1) ? $clog2(S) : 1;
  localparam int WW = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam int KW = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;

  localparam logic signed [11:0] X_MIN       = 12'(-(SCREEN_W / 2));
  localparam logic signed [11:0] X_LAST_BASE = 12'(SCREEN_W / 2 - S);
  localparam logic signed [11:0] Y_MIN       = 12'(-(SCREEN_H / 2));
  localparam logic signed [11:0] Y_MAX       = 12'(SCREEN_H / 2 - 1);
  localparam logic signed [11:0] S_STEP      = 12'(S);

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    WAIT_DONE,
    RELEASE,
    DRAIN,
    ADVANCE
  } state_t;

  state_t state_q, state_d;

  logic signed [11:0] strip_base_q;
  logic signed [11:0] row_q;
  logic [N_WORKERS-1:0] seen_busy_q;
  Types::Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] result_q;

  // Drain position: p_q is the pixel offset inside the strip, while dw_q/dk_q
  // track p mod N_WORKERS and p / N_WORKERS incrementally to avoid dividers.
  logic [PW-1:0] p_q;
  logic [WW-1:0] dw_q;
  logic [KW-1:0] dk_q;

  logic all_done;
  logic last_p;
  logic last_strip;
  logic last_row;

  // A worker counts as done only after it has been seen busy and then
  // dropped busy, so a worker that has not yet started is never mistaken
  // for one that has finished.
  assign all_done   = &(seen_busy_q & ~w_busy);
  assign last_p     = (p_q == PW'(S - 1));
  assign last_strip = (strip_base_q == X_LAST_BASE);
  assign last_row   = (row_q == Y_MAX);

  assign w_pixel_start_x = strip_base_q;
  assign w_pixel_y       = row_q;

`ifdef SCHEDULER_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        sched_error_q;
  logic        to_hit;

  // to_cnt_q holds (WAIT_DONE cycles elapsed - 1), so this fires on the
  // 65535th consecutive WAIT_DONE cycle.
  assign to_hit      = (state_q == WAIT_DONE) && (to_cnt_q == 16'hFFFE) && !all_done;
  assign sched_error = sched_error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q      <= '0;
      sched_error_q <= 1'b0;
    end else begin
      if (state_q == WAIT_DONE) begin
        to_cnt_q <= to_cnt_q + 16'd1;
      end else begin
        to_cnt_q <= '0;
      end
      if (to_hit) begin
        sched_error_q <= 1'b1;
      end
    end
  end
`else
  assign sched_error = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs. Worker activation and px_valid are
  // pure decodes of the state register so that reset removes them at once.
  always_comb begin
    state_d    = state_q;
    w_activate = '0;
    px_valid   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        w_activate = '1;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        w_activate = '1;
        if (all_done) begin
          state_d = RELEASE;
        end
`ifdef SCHEDULER_TIMEOUT_EN
        else if (to_hit) begin
          state_d = IDLE;
        end
`endif
      end
      RELEASE: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        px_valid = 1'b1;
        if (px_ready && last_p) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if (last_strip && last_row) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = DISPATCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel stream outputs are zero outside DRAIN; inside DRAIN they are a
  // function of registers that only move on a completed handshake.
  always_comb begin
    px_x     = '0;
    px_y     = '0;
    px_color = '0;
    if (px_valid) begin
      px_x     = $signed(strip_base_q + $signed({{(12 - PW){1'b0}}, p_q}));
      px_y     = row_q;
      px_color = result_q[dw_q][dk_q];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strip_base_q <= '0;
      row_q        <= '0;
      seen_busy_q  <= '0;
      result_q     <= '0;
      p_q          <= '0;
      dw_q         <= '0;
      dk_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            strip_base_q <= X_MIN;
            row_q        <= Y_MIN;
          end
        end
        DISPATCH: begin
          seen_busy_q <= '0;
        end
        WAIT_DONE: begin
          seen_busy_q <= seen_busy_q | w_busy;
        end
        RELEASE: begin
          result_q <= w_buffer;
          p_q      <= '0;
          dw_q     <= '0;
          dk_q     <= '0;
        end
        DRAIN: begin
          if (px_ready) begin
            p_q <= p_q + PW'(1);
            if (dw_q == WW'(N_WORKERS - 1)) begin
              dw_q <= '0;
              dk_q <= dk_q + KW'(1);
            end else begin
              dw_q <= dw_q + WW'(1);
            end
          end
        end
        ADVANCE: begin
          if (last_strip) begin
            strip_base_q <= X_MIN;
            if (!last_row) begin
              row_q <= row_q + 12'sd1;
            end
          end else begin
            strip_base_q <= strip_base_q + S_STEP;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Randomized scoreboard bench for raytracing_scheduler on a reduced screen.
// Worker models publish correct results only when they drop busy.
// Expected pixels come from a plain raster walk of the screen.

module tb_raytracing_scheduler;

  localparam int N = 4;
  localparam int J = 2;
  localparam int S = N * J;
  localparam int W = 32;
  localparam int H = 4;
  localparam int FRAME_PX = W * H;

  logic clk = 1'b0;
  logic reset_n;
  logic frame_start;
  logic frame_done;
  logic [N-1:0] w_activate;
  logic signed [11:0] w_pixel_start_x;
  logic signed [11:0] w_pixel_y;
  logic [N-1:0] w_busy;
  Types::Color [N-1:0][J-1:0] w_buffer;
  logic px_valid;
  logic px_ready;
  logic signed [11:0] px_x;
  logic signed [11:0] px_y;
  Types::Color px_color;
  logic sched_error;

  always #5 clk = ~clk;

  raytracing_scheduler #(
    .N_WORKERS(N),
    .JOBS_SUBDIVISION(J),
    .SCREEN_W(W),
    .SCREEN_H(H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .w_activate(w_activate),
    .w_pixel_start_x(w_pixel_start_x),
    .w_pixel_y(w_pixel_y),
    .w_busy(w_busy),
    .w_buffer(w_buffer),
    .px_valid(px_valid),
    .px_ready(px_ready),
    .px_x(px_x),
    .px_y(px_y),
    .px_color(px_color),
    .sched_error(sched_error)
  );

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
    Types::Color        c;
  } pix_t;

  pix_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [23:0] salt = '0;
  int busy_len[N];
  bit ready_always = 1'b1;
  bit check_run = 1'b0;

  function automatic Types::Color shade(logic signed [11:0] x, logic signed [11:0] y, logic [23:0] s);
    return {x, y} ^ s;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Worker models: busy rises one cycle after activate, lasts busy_len
  // cycles (0 = random 1..20), and the buffer holds garbage until busy drops.
  int wst[N];
  int wrem[N];
  logic signed [11:0] wx[N];
  logic signed [11:0] wy[N];

  always @(negedge clk) begin
    for (int w = 0; w < N; w++) begin
      if (!w_activate[w]) begin
        w_busy[w] = 1'b0;
        wst[w] = 0;
      end else begin
        case (wst[w])
          0: begin
            wx[w] = w_pixel_start_x;
            wy[w] = w_pixel_y;
            for (int k = 0; k < J; k++) w_buffer[w][k] = 24'($urandom);
            wst[w] = 1;
          end
          1: begin
            w_busy[w] = 1'b1;
            wrem[w] = (busy_len[w] == 0) ? int'($urandom_range(1, 20)) : busy_len[w];
            wst[w] = 2;
          end
          2: begin
            wrem[w]--;
            if (wrem[w] == 0) begin
              w_busy[w] = 1'b0;
              for (int k = 0; k < J; k++)
                w_buffer[w][k] = shade(wx[w] + 12'(w + k * N), wy[w], salt);
              wst[w] = 3;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Monitor: drives px_ready, pops the scoreboard on each handshake, checks
  // hold-during-stall, no worker activity while draining and drain length.
  bit prev_stall = 1'b0;
  pix_t hold;
  int run = 0;

  always @(negedge clk) begin
    pix_t got;
    pix_t e;
    px_ready = ready_always ? 1'b1 : 1'($urandom % 2);
    if (!reset_n) begin
      prev_stall = 1'b0;
      run = 0;
    end else begin
      got = '{x: px_x, y: px_y, c: px_color};
      if (frame_done) done_cnt++;
      if (prev_stall) begin
        vectors++;
        if (!px_valid || got !== hold) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%0b (%0d,%0d,%06h) expected v=1 (%0d,%0d,%06h)",
                   px_valid, got.x, got.y, got.c, hold.x, hold.y, hold.c);
        end
      end
      if (px_valid) begin
        vectors++;
        if (w_activate !== '0) begin
          miscompares++;
          $display("FAIL overlap: got w_activate=%0h expected 0 while draining", w_activate);
        end
        run++;
      end else begin
        if (run > 0 && check_run) chk("drain_len", 64'(run), 64'(S));
        run = 0;
      end
      if (px_valid && px_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pixel: got (%0d,%0d,%06h) expected no pixel", got.x, got.y, got.c);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL pixel: got (%0d,%0d,%06h) expected (%0d,%0d,%06h)",
                     got.x, got.y, got.c, e.x, e.y, e.c);
          end
        end
      end
      prev_stall = px_valid && !px_ready;
      hold = got;
    end
  end

  task automatic push_frame();
    pix_t e;
    salt = 24'($urandom);
    for (int y = -H / 2; y < H / 2; y++) begin
      for (int x = -W / 2; x < W / 2; x++) begin
        e.x = 12'(x);
        e.y = 12'(y);
        e.c = shade(e.x, e.y, salt);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(bit rdy_hi, bit chk_run, int l0, int l1, int l2, int l3);
    int target;
    int cyc;
    ready_always = rdy_hi;
    check_run = chk_run;
    busy_len[0] = l0; busy_len[1] = l1; busy_len[2] = l2; busy_len[3] = l3;
    push_frame();
    target = done_cnt;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    cyc = 0;
    while (done_cnt == target && cyc < 30000) begin
      @(negedge clk);
      frame_start = ($urandom % 40 == 0);  // must be ignored mid-frame
      cyc++;
    end
    frame_start = 1'b0;
    if (cyc >= 30000) begin
      miscompares++;
      $display("FAIL frame_timeout: got no frame_done expected one within 30000 cycles");
    end
    chk("frame_all_pixels", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("frame_done_one_cycle", 64'(frame_done), 64'd0);
    chk("frame_done_count", 64'(done_cnt), 64'(target + 1));
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0;
    frame_start = 1'b0;
    px_ready = 1'b0;
    w_busy = '0;
    w_buffer = '0;
    for (int w = 0; w < N; w++) begin
      busy_len[w] = 0;
      wst[w] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_activate", 64'(w_activate), 64'd0);
    chk("rst_px_valid", 64'(px_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_sched_error", 64'(sched_error), 64'd0);
    chk("rst_start_x", 64'(w_pixel_start_x), 64'd0);
    chk("rst_pixel_y", 64'(w_pixel_y), 64'd0);
    chk("rst_px_x", 64'(px_x), 64'd0);
    chk("rst_px_y", 64'(px_y), 64'd0);
    chk("rst_px_color", 64'(px_color), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1'b1, 1'b1, 20, 20, 20, 20);
    run_frame(1'b0, 1'b0, 0, 0, 0, 0);
    run_frame(1'b0, 1'b0, 0, 0, 0, 0);
    run_frame(1'b1, 1'b1, 50, 50, 1, 50);

    // Reset while strip 3 of row 0 is being worked on.
    ready_always = 1'b0;
    check_run = 1'b0;
    for (int w = 0; w < N; w++) busy_len[w] = 0;
    push_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    cyc = 0;
    while (!(w_activate != '0 && w_pixel_start_x == 12'sd8 && w_pixel_y == -12'sd2) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 5000) begin
      miscompares++;
      $display("FAIL strip3_reach: got no dispatch at x=8 expected one within 5000 cycles");
    end
    chk("strip3_pixels_consumed", 64'(exp_q.size()), 64'(FRAME_PX - 3 * S));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_activate", 64'(w_activate), 64'd0);
    chk("midrst_px_valid", 64'(px_valid), 64'd0);
    chk("midrst_frame_done", 64'(frame_done), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1'b0, 1'b0, 0, 0, 0, 0);
    chk("total_frames", 64'(done_cnt), 64'd5);
    chk("sched_error_final", 64'(sched_error), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
